sargantana_icache_way_array: RTL

Multi-way instruction-cache data array with an integrated refill line buffer. Reads all NUM_WAYS ways of one set in parallel with a one-cycle latency for tag compare downstream. It collects a refill line as BEATS narrow beats, then commits it to the selected way in a single SRAM write. It sits between the icache controller (read and fill requests) and the per-way single-port SRAMs.

---
 rtl/sargantana_icache_pkg.sv | 21 ++
 rtl/sargantana_icache_fill_buffer.sv | 108 ++++++++++
 rtl/sargantana_icache_way.sv | 30 +++
 rtl/sargantana_icache_way_array.sv | 96 +++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// rtl/sargantana_icache_pkg.sv - shared types and width helpers for the icache way array
package sargantana_icache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } fill_state_t;

    localparam int unsigned DEF_SET_WIDTH  = 256;
    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned DEF_NUM_WAYS   = 4;
    localparam int unsigned DEF_BEAT_WIDTH = 64;
    localparam int unsigned DEF_BEATS      = DEF_SET_WIDTH / DEF_BEAT_WIDTH;

    // Index width for n items, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/sargantana_icache_fill_buffer.sv
// rtl/sargantana_icache_fill_buffer.sv - refill beat collector and commit FSM
module sargantana_icache_fill_buffer
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned SET_WIDTH  = 256,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned BEAT_WIDTH = 64,
    localparam int unsigned BEATS     = SET_WIDTH / BEAT_WIDTH,
    localparam int unsigned CNT_W     = idx_width(BEATS),
    localparam int unsigned WAY_W     = idx_width(NUM_WAYS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fill_valid_i,
    output logic                  fill_ready_o,
    input  logic [BEAT_WIDTH-1:0] fill_beat_i,
    input  logic [ADDR_WIDTH-1:0] fill_addr_i,
    input  logic [WAY_W-1:0]      fill_way_i,
    input  logic                  fill_abort_i,
    output logic                  fill_done_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [WAY_W-1:0]      wr_way_o,
    output logic [SET_WIDTH-1:0]  wr_line_o
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    fill_state_t           state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [BEAT_WIDTH-1:0] line_q [BEATS];
    logic [BEAT_WIDTH-1:0] line_d [BEATS];
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WAY_W-1:0]      way_q, way_d;
    logic                  beat_take;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        line_d       = line_q;
        addr_d       = addr_q;
        way_d        = way_q;
        fill_ready_o = (state_q != WRITE);
        beat_take    = fill_valid_i && fill_ready_o && !fill_abort_i;

        case (state_q)
            IDLE, COLLECT: begin
                // Abort wins over a beat in the same cycle, even the last one.
                if (fill_abort_i) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end else if (beat_take) begin
                    line_d[beat_cnt_q] = fill_beat_i;
                    if (state_q == IDLE) begin
                        addr_d = fill_addr_i;
                        way_d  = fill_way_i;
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = WRITE;
                        beat_cnt_d = '0;
                    end else begin
                        state_d    = COLLECT;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Line data and target are qualified by the FSM, so they carry no reset.
    always_ff @(posedge clk_i) begin
        line_q <= line_d;
        addr_q <= addr_d;
        way_q  <= way_d;
    end

    always_comb begin
        wr_line_o = '0;
        for (int k = 0; k < int'(BEATS); k++) begin
            wr_line_o[k*BEAT_WIDTH +: BEAT_WIDTH] = line_q[k];
        end
    end

    assign wr_en_o     = (state_q == WRITE);
    assign fill_done_o = (state_q == WRITE);
    assign wr_addr_o   = addr_q;
    assign wr_way_o    = way_q;

endmodule

// File: rtl/sargantana_icache_way.sv
// rtl/sargantana_icache_way.sv - single-port line SRAM model for one cache way
module sargantana_icache_way #(
    parameter int unsigned SET_WIDTH  = 256,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [SET_WIDTH-1:0]  wdata_i,
    output logic [SET_WIDTH-1:0]  rdata_o
);

    logic [SET_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [SET_WIDTH-1:0] rdata_q;

    // Read data holds its last value when the port is idle or writing.
    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sargantana_icache_way_array.sv
// rtl/sargantana_icache_way_array.sv - multi-way icache data array with refill line buffer
module sargantana_icache_way_array
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned SET_WIDTH  = 256,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned BEAT_WIDTH = 64,
    localparam int unsigned WAY_W     = idx_width(NUM_WAYS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           rd_req_i,
    output logic                           rd_ready_o,
    input  logic [ADDR_WIDTH-1:0]          rd_addr_i,
    output logic                           rd_valid_o,
    output logic [NUM_WAYS*SET_WIDTH-1:0]  rd_data_o,
    input  logic                           fill_valid_i,
    output logic                           fill_ready_o,
    input  logic [BEAT_WIDTH-1:0]          fill_beat_i,
    input  logic [ADDR_WIDTH-1:0]          fill_addr_i,
    input  logic [WAY_W-1:0]               fill_way_i,
    input  logic                           fill_abort_i,
    output logic                           fill_done_o
);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WAY_W-1:0]      wr_way;
    logic [SET_WIDTH-1:0]  wr_line;
    logic                  rd_accept;
    logic                  rd_valid_q, rd_valid_d;
    logic [NUM_WAYS-1:0]   way_req;
    logic [NUM_WAYS-1:0]   way_we;
    logic [ADDR_WIDTH-1:0] way_addr;

    sargantana_icache_fill_buffer #(
        .SET_WIDTH  (SET_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WAYS   (NUM_WAYS),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_fill_buffer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fill_valid_i (fill_valid_i),
        .fill_ready_o (fill_ready_o),
        .fill_beat_i  (fill_beat_i),
        .fill_addr_i  (fill_addr_i),
        .fill_way_i   (fill_way_i),
        .fill_abort_i (fill_abort_i),
        .fill_done_o  (fill_done_o),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_way_o     (wr_way),
        .wr_line_o    (wr_line)
    );

    // Reads are blocked during the commit cycle, so one shared address suffices.
    always_comb begin
        rd_ready_o = !wr_en;
        rd_accept  = rd_req_i && rd_ready_o;
        rd_valid_d = rd_accept;
        way_addr   = wr_en ? wr_addr : rd_addr_i;
        way_we     = '0;
        way_req    = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            way_we[w]  = wr_en && (wr_way == WAY_W'(w));
            way_req[w] = way_we[w] || rd_accept;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid_o = rd_valid_q;

    for (genvar w = 0; w < int'(NUM_WAYS); w++) begin : g_way
        sargantana_icache_way #(
            .SET_WIDTH  (SET_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_way (
            .clk_i   (clk_i),
            .req_i   (way_req[w]),
            .we_i    (way_we[w]),
            .addr_i  (way_addr),
            .wdata_i (wr_line),
            .rdata_o (rd_data_o[w*SET_WIDTH +: SET_WIDTH])
        );
    end

endmodule
